int_sequencer: RTL

- Sequences 6502 interrupt entry for the core: RES, NMI, BRK and IRQ.
- Arbitrates pending sources at instruction boundaries.
- Drives the stack pushes (PCH, PCL, P) and the vector fetch (lo, hi), then hands the new PC, SP and I flag to the core.
- Sits between the interrupt sampling logic (take_irq/take_nmi pulses) and the core's memory port.

---
 rtl/int_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/int_sequencer.sv
// 6502 interrupt entry sequencer: arbitrates RES/NMI/BRK/IRQ at instruction
// boundaries, pushes PCH/PCL/P, fetches the vector and hands PC/SP/I to the core.
module int_sequencer #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_RES    = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        take_irq,
  input  logic        take_nmi,
  input  logic        res_req,
  input  logic        brk_req,
  input  logic        boundary,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  sp_in,
  input  logic        mem_ready,
  input  logic [7:0]  mem_din,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_dout,
  output logic        mem_we,
  output logic        mem_re,
  output logic        busy,
  output logic        pc_load,
  output logic [15:0] pc_out,
  output logic [7:0]  sp_out,
  output logic        set_i,
  output logic        irq_ack,
  output logic        nmi_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI, S_FINISH
  } state_t;

  typedef enum logic [1:0] {SRC_RES, SRC_NMI, SRC_BRK, SRC_IRQ} src_t;

  state_t      state_q, state_d;
  src_t        src_q, src_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        res_pend_q, res_pend_d;
  logic [7:0]  sp_q, sp_d;
  logic [7:0]  p_q, p_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] vec_q, vec_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        irq_ack_q, irq_ack_d;
  logic        nmi_ack_q, nmi_ack_d;

  logic        nmi_clr, res_clr;
  logic        accept;
  src_t        acc_src;
  logic        writes;
  logic [7:0]  push_data;

  // Status byte as it lands on the stack: bit 5 always set, B only for BRK.
  function automatic logic [7:0] stacked_p(input logic [7:0] p, input logic is_brk);
    logic [7:0] r;
    r    = p | 8'h20;
    r[4] = is_brk;
    return r;
  endfunction

  always_comb begin
    accept  = 1'b0;
    acc_src = SRC_IRQ;
    if (res_pend_q || res_req) begin
      accept  = 1'b1;
      acc_src = SRC_RES;
    end else if (boundary) begin
      if (nmi_pend_q || take_nmi) begin
        accept  = 1'b1;
        acc_src = SRC_NMI;
      end else if (brk_req) begin
        accept  = 1'b1;
        acc_src = SRC_BRK;
      end else if (take_irq) begin
        accept  = 1'b1;
        acc_src = SRC_IRQ;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    sp_d      = sp_q;
    p_d       = p_q;
    pc_d      = pc_q;
    vec_d     = vec_q;
    pc_out_d  = pc_out_q;
    irq_ack_d = 1'b0;
    nmi_ack_d = 1'b0;
    nmi_clr   = 1'b0;
    res_clr   = 1'b0;
    mem_addr  = 16'h0000;
    mem_dout  = 8'h00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    pc_load   = 1'b0;
    set_i     = 1'b0;
    sp_out    = 8'h00;
    busy      = (state_q != S_IDLE);
    writes    = (src_q != SRC_RES);
    push_data = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_PUSH_PCH;
          src_d     = acc_src;
          pc_d      = pc_in;
          p_d       = p_in;
          sp_d      = sp_in;
          irq_ack_d = (acc_src == SRC_BRK) || (acc_src == SRC_IRQ);
        end
      end

      S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
        case (state_q)
          S_PUSH_PCH: push_data = pc_q[15:8];
          S_PUSH_PCL: push_data = pc_q[7:0];
          default:    push_data = stacked_p(p_q, src_q == SRC_BRK);
        endcase
        // Reset walks the same stack addresses but only reads them.
        mem_addr = {STACK_PAGE, sp_q};
        mem_we   = writes;
        mem_re   = !writes;
        mem_dout = writes ? push_data : 8'h00;
        if (mem_ready) begin
          sp_d = sp_q - 8'd1;
          case (state_q)
            S_PUSH_PCH: state_d = S_PUSH_PCL;
            S_PUSH_PCL: state_d = S_PUSH_P;
            default: begin
              state_d = S_VEC_LO;
              // A pending NMI steals an IRQ/BRK entry at vector selection.
              if (src_q == SRC_RES) begin
                vec_d   = VEC_RES;
                res_clr = 1'b1;
              end else if ((src_q == SRC_NMI) || nmi_pend_q) begin
                vec_d     = VEC_NMI;
                nmi_clr   = 1'b1;
                nmi_ack_d = 1'b1;
              end else begin
                vec_d = VEC_IRQ;
              end
            end
          endcase
        end
      end

      S_VEC_LO: begin
        mem_addr = vec_q;
        mem_re   = 1'b1;
        if (mem_ready) begin
          pc_out_d[7:0] = mem_din;
          state_d       = S_VEC_HI;
        end
      end

      S_VEC_HI: begin
        mem_addr = vec_q + 16'd1;
        mem_re   = 1'b1;
        if (mem_ready) begin
          pc_out_d[15:8] = mem_din;
          state_d        = S_FINISH;
        end
      end

      S_FINISH: begin
        pc_load = 1'b1;
        set_i   = 1'b1;
        sp_out  = sp_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // A pulse arriving in the clearing cycle wins, so no event is dropped.
  assign nmi_pend_d = take_nmi | (nmi_pend_q & ~nmi_clr);
  assign res_pend_d = res_req  | (res_pend_q & ~res_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_q      <= SRC_RES;
      nmi_pend_q <= 1'b0;
      res_pend_q <= 1'b0;
      sp_q       <= 8'h00;
      p_q        <= 8'h00;
      pc_q       <= 16'h0000;
      vec_q      <= 16'h0000;
      pc_out_q   <= 16'h0000;
      irq_ack_q  <= 1'b0;
      nmi_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      nmi_pend_q <= nmi_pend_d;
      res_pend_q <= res_pend_d;
      sp_q       <= sp_d;
      p_q        <= p_d;
      pc_q       <= pc_d;
      vec_q      <= vec_d;
      pc_out_q   <= pc_out_d;
      irq_ack_q  <= irq_ack_d;
      nmi_ack_q  <= nmi_ack_d;
    end
  end

  assign pc_out  = pc_out_q;
  assign irq_ack = irq_ack_q;
  assign nmi_ack = nmi_ack_q;

endmodule
